id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Operand-collect stage directly downstream of the register file read ports. Takes the two
//  read-port values, applies EX/MEM and MEM/WB result forwarding, and detects load-use
//  hazards. Issues the resolved operands into the ID/EX pipeline register through a
//  valid/ready handshake; the ALU stage consumes that register.
// PARAMETERS
//  DATA_W   32  operand / result width
//  REG_AW    5  register index width (32 GPRs; index 0 hardwired zero)
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       synchronous, active-high
//  id_valid      in   1       decode has an instruction this cycle
//  id_ready      out  1       stage accepts decode instruction (handshake completes on valid&ready)
//  id_rs, id_rt  in   REG_AW  source indices (same indices drive register file read ports)
//  id_dst        in   REG_AW  destination index
//  id_reg_write  in   1       instruction writes id_dst
//  id_mem_read   in   1       instruction is a load
//  rf_data1/2    in   DATA_W  register file read data for id_rs / id_rt
//  mem_reg_write in   1       EX/MEM instr writes a register
//  mem_is_load   in   1       EX/MEM instr is a load (its data is not yet available)
//  mem_dst       in   REG_AW  EX/MEM destination
//  mem_data      in   DATA_W  EX/MEM ALU result
//  wb_reg_write  in   1       MEM/WB write enable (same signal as register file RegWrite)
//  wb_dst        in   REG_AW  MEM/WB destination (register file WriteReg)
//  wb_data       in   DATA_W  MEM/WB data (register file WriteData)
//  flush         in   1       kill the ID/EX entry and the decode-side instruction
//  ex_ready      in   1       ALU stage consumes the ID/EX entry
//  ex_valid      out  1       ID/EX entry valid
//  ex_op_a/b     out  DATA_W  resolved operands for rs / rt
//  ex_dst        out  REG_AW  destination
//  ex_reg_write  out  1       write enable; ex_mem_read out 1: load flag
//  hazard_stall  out  1       load-use stall this cycle (combinational)
// BEHAVIOUR
//  - Reset: ex_valid=0, ex_op_a=ex_op_b=0, ex_dst=0, ex_reg_write=0, ex_mem_read=0.
//  - Source match for index s: s!=0 AND enable AND dst==s. Index 0 never matches; its operand is 0.
//  - Operand select priority per source: (1) mem match -> mem_data; (2) wb match (bypass
//    macro only) -> wb_data; (3) rf_data.
//  - hazard_stall = id_valid & (match on rs or rt against ID/EX when ex_valid&ex_mem_read&
//    ex_reg_write, OR against EX/MEM when mem_is_load&mem_reg_write).
//  - load_ready = !ex_valid | ex_ready.  id_ready = load_ready & !hazard_stall & !flush.
//  - Each clock, in priority order:
//    * flush: ex_valid<=0; the decode instruction is not accepted.
//    * load_ready & id_valid & !hazard_stall: load ID/EX, ex_valid<=1 (1-cycle latency).
//    * load_ready & hazard_stall: bubble; ex_valid<=0 and ex_reg_write<=0.
//    * otherwise: hold every ID/EX field unchanged (operands are not re-resolved).
//  - While stalled, the bench holds id_* stable and operands re-resolve each cycle; the
//    stall releases when the load leaves EX/MEM (at most 2 cycles behind the load).
//  - Simultaneous flush and ex_ready: flush wins; the entry is dropped.
//  - Reset asserted mid-stall clears the entry; id_ready follows the combinational equation.
// CONFIGURATION
//  OPFWD_WB_BYPASS_EN defined: when wb_reg_write and wb_dst==s!=0, the operand takes
//    wb_data. This covers the register file writing at the clock edge while reading
//    combinationally in the same cycle.
//  OPFWD_WB_BYPASS_EN undefined: no WB forwarding path. Decode must separate a WB write
//    and a read of the same register by one cycle; the stage returns the stale rf_data.
// TESTING
//  1 reset; clocks with id_valid=0 -> ex_valid=0, all outputs 0, id_ready=1.
//  2 rs=3, rf_data1=5, mem_reg_write=1, mem_dst=3, mem_data=0xAA -> ex_op_a=0xAA after 1 clk.
//  3 rs=0, mem_dst=0, mem_data=0xFF, rf_data1=0x12 -> ex_op_a=0 (no forwarding to r0).
//  4 lw r4 in ID/EX, next instr rs=4 -> hazard_stall=1, id_ready=0, bubble issued;
//    load in EX/MEM -> stall again; load at WB -> accepted. With bypass, ex_op_a=wb_data.
//  5 wb_reg_write=1, wb_dst=7, wb_data=0x55, rf_data2=0x11, rt=7 -> ex_op_b=0x55 with
//    bypass, 0x11 without.
//  6 ex_valid=1, ex_ready=0 for 3 cycles -> ID/EX held, id_ready=0; flush -> ex_valid=0 next clock.

Source files
------------

// File: rtl/id_operand_stage_if.sv
// Bundle of decode-side, forwarding-source and ID/EX-side signals for the
// operand-collect stage. The stage uses the slave view; whatever drives
// decode, the later pipeline stages and the ALU consumer uses the master view.
interface id_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Decode side
  logic              id_valid;
  logic              id_ready;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  // EX/MEM forwarding source
  logic              mem_reg_write;
  logic              mem_is_load;
  logic [REG_AW-1:0] mem_dst;
  logic [DATA_W-1:0] mem_data;
  // MEM/WB forwarding source (shared with the register file write port)
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  // Pipeline control and ID/EX side
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              hazard_stall;

  modport slave (
    input  id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
    input  rf_data1, rf_data2,
    input  mem_reg_write, mem_is_load, mem_dst, mem_data,
    input  wb_reg_write, wb_dst, wb_data,
    input  flush, ex_ready,
    output id_ready, ex_valid, ex_op_a, ex_op_b, ex_dst,
    output ex_reg_write, ex_mem_read, hazard_stall
  );

  modport master (
    output id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
    output rf_data1, rf_data2,
    output mem_reg_write, mem_is_load, mem_dst, mem_data,
    output wb_reg_write, wb_dst, wb_data,
    output flush, ex_ready,
    input  id_ready, ex_valid, ex_op_a, ex_op_b, ex_dst,
    input  ex_reg_write, ex_mem_read, hazard_stall
  );
endinterface

// File: rtl/id_operand_stage.sv
// Operand-collect stage: resolves the two register-file read values against
// the EX/MEM (and optionally MEM/WB) results, detects load-use hazards and
// issues the resolved instruction into the ID/EX register via valid/ready.
// Optional feature macro: OPFWD_WB_BYPASS_EN enables MEM/WB -> operand
// forwarding; without it the stage returns the register-file value as read.
module id_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          clock,
  input  logic          reset,
  id_operand_stage_if.slave bus
);

  // A producer matches a source when it writes that (non-zero) register.
  function automatic logic src_match(input logic [REG_AW-1:0] s,
                                     input logic              en,
                                     input logic [REG_AW-1:0] dst);
    return (s != '0) && en && (dst == s);
  endfunction

  logic              ex_valid_q,     ex_valid_d;
  logic [DATA_W-1:0] ex_op_a_q,      ex_op_a_d;
  logic [DATA_W-1:0] ex_op_b_q,      ex_op_b_d;
  logic [REG_AW-1:0] ex_dst_q,       ex_dst_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;

  logic              mem_hit_a, mem_hit_b;
  logic              wb_hit_a,  wb_hit_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic              exload_a, exload_b, memload_a, memload_b;
  logic              hazard;
  logic              load_ready;

  // Forwarding source selection for each operand.
  always_comb begin
    mem_hit_a = src_match(bus.id_rs, bus.mem_reg_write, bus.mem_dst);
    mem_hit_b = src_match(bus.id_rt, bus.mem_reg_write, bus.mem_dst);
`ifdef OPFWD_WB_BYPASS_EN
    wb_hit_a  = src_match(bus.id_rs, bus.wb_reg_write, bus.wb_dst);
    wb_hit_b  = src_match(bus.id_rt, bus.wb_reg_write, bus.wb_dst);
`else
    wb_hit_a  = 1'b0;
    wb_hit_b  = 1'b0;
`endif

    // r0 always reads as zero whatever the register file returns.
    if (bus.id_rs == '0)  op_a = '0;
    else if (mem_hit_a)   op_a = bus.mem_data;
    else if (wb_hit_a)    op_a = bus.wb_data;
    else                  op_a = bus.rf_data1;

    if (bus.id_rt == '0)  op_b = '0;
    else if (mem_hit_b)   op_b = bus.mem_data;
    else if (wb_hit_b)    op_b = bus.wb_data;
    else                  op_b = bus.rf_data2;
  end

  // Load-use hazard against a load in ID/EX or in EX/MEM, plus handshake.
  always_comb begin
    exload_a  = src_match(bus.id_rs, ex_valid_q & ex_mem_read_q & ex_reg_write_q, ex_dst_q);
    exload_b  = src_match(bus.id_rt, ex_valid_q & ex_mem_read_q & ex_reg_write_q, ex_dst_q);
    memload_a = src_match(bus.id_rs, bus.mem_is_load & bus.mem_reg_write, bus.mem_dst);
    memload_b = src_match(bus.id_rt, bus.mem_is_load & bus.mem_reg_write, bus.mem_dst);
    hazard     = bus.id_valid & (exload_a | exload_b | memload_a | memload_b);
    load_ready = ~ex_valid_q | bus.ex_ready;
  end

  // Next state of the ID/EX register: flush, load, bubble, or hold.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_op_a_d      = ex_op_a_q;
    ex_op_b_d      = ex_op_b_q;
    ex_dst_d       = ex_dst_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (load_ready && bus.id_valid && !hazard) begin
      ex_valid_d     = 1'b1;
      ex_op_a_d      = op_a;
      ex_op_b_d      = op_b;
      ex_dst_d       = bus.id_dst;
      ex_reg_write_d = bus.id_reg_write;
      ex_mem_read_d  = bus.id_mem_read;
    end else if (load_ready && hazard) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
    end
  end

  // ID/EX register with synchronous reset.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values; reset is sampled on the clock edge only.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_op_a_q      <= '0;
      ex_op_b_q      <= '0;
      ex_dst_q       <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_op_a_q      <= ex_op_a_d;
      ex_op_b_q      <= ex_op_b_d;
      ex_dst_q       <= ex_dst_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
    end
  end

  assign bus.id_ready     = load_ready & ~hazard & ~bus.flush;
  assign bus.hazard_stall = hazard;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_op_a      = ex_op_a_q;
  assign bus.ex_op_b      = ex_op_b_q;
  assign bus.ex_dst       = ex_dst_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_mem_read  = ex_mem_read_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// random traffic, all compared against a behavioural model of the ID/EX entry.
module tb_id_operand_stage;

`ifdef OPFWD_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  id_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference view of the ID/EX entry.
  typedef struct {
    bit        valid;
    bit [31:0] a;
    bit [31:0] b;
    bit [4:0]  dst;
    bit        rw;
    bit        mr;
  } entry_t;

  entry_t m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Operand value an instruction should see for source register s.
  function automatic bit [31:0] m_operand(input bit [4:0] s, input bit [31:0] rf);
    if (s == 0) return 32'h0;
    if (bus.mem_reg_write && bus.mem_dst == s) return bus.mem_data;
    if (BYPASS && bus.wb_reg_write && bus.wb_dst == s) return bus.wb_data;
    return rf;
  endfunction

  // A source waits while the load producing it has not yet reached WB.
  function automatic bit m_hazard();
    bit       hit = 1'b0;
    bit [4:0] srcs [2];
    srcs[0] = bus.id_rs;
    srcs[1] = bus.id_rt;
    foreach (srcs[i]) begin
      if (srcs[i] != 0) begin
        if (m.valid && m.mr && m.rw && m.dst == srcs[i]) hit = 1'b1;
        if (bus.mem_is_load && bus.mem_reg_write && bus.mem_dst == srcs[i]) hit = 1'b1;
      end
    end
    return bus.id_valid && hit;
  endfunction

  // One cycle: check combinational outputs, advance the model, clock, check the entry.
  task automatic step(input string tag);
    bit hz, lr, rdy;
    #1;
    hz  = m_hazard();
    lr  = !m.valid || bus.ex_ready;
    rdy = lr && !hz && !bus.flush;
    check({tag, ".hazard"},   {31'b0, bus.hazard_stall}, {31'b0, hz});
    check({tag, ".id_ready"}, {31'b0, bus.id_ready},     {31'b0, rdy});
    if (reset) begin
      m = '{default: 0};
    end else if (bus.flush) begin
      m.valid = 1'b0;
    end else if (lr && bus.id_valid && !hz) begin
      m.valid = 1'b1;
      m.a     = m_operand(bus.id_rs, bus.rf_data1);
      m.b     = m_operand(bus.id_rt, bus.rf_data2);
      m.dst   = bus.id_dst;
      m.rw    = bus.id_reg_write;
      m.mr    = bus.id_mem_read;
    end else if (lr && hz) begin
      m.valid = 1'b0;
      m.rw    = 1'b0;
    end
    @(posedge clock);
    #1;
    check({tag, ".ex_valid"}, {31'b0, bus.ex_valid},     {31'b0, m.valid});
    check({tag, ".ex_op_a"},  bus.ex_op_a,               m.a);
    check({tag, ".ex_op_b"},  bus.ex_op_b,               m.b);
    check({tag, ".ex_dst"},   {27'b0, bus.ex_dst},       {27'b0, m.dst});
    check({tag, ".ex_rw"},    {31'b0, bus.ex_reg_write}, {31'b0, m.rw});
    check({tag, ".ex_mr"},    {31'b0, bus.ex_mem_read},  {31'b0, m.mr});
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_dst = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.rf_data1 = 0; bus.rf_data2 = 0;
    bus.mem_reg_write = 0; bus.mem_is_load = 0; bus.mem_dst = 0; bus.mem_data = 0;
    bus.wb_reg_write = 0; bus.wb_dst = 0; bus.wb_data = 0;
    bus.flush = 0; bus.ex_ready = 1;
  endtask

  // Put "lw r4" into ID/EX.
  task automatic issue_load_r4(input string tag);
    clear_inputs();
    bus.id_valid = 1; bus.id_dst = 4; bus.id_reg_write = 1; bus.id_mem_read = 1;
    step(tag);
  endtask

  initial begin
    m = '{default: 0};
    clear_inputs();

    // Reset, then idle clocks.
    reset = 1;
    step("rst0");
    step("rst1");
    check("rst.ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    check("rst.id_ready", {31'b0, bus.id_ready}, 32'h1);
    reset = 0;
    step("idle0");
    step("idle1");

    // EX/MEM forwarding beats the register file.
    bus.id_valid = 1; bus.id_rs = 3; bus.rf_data1 = 5;
    bus.mem_reg_write = 1; bus.mem_dst = 3; bus.mem_data = 32'hAA;
    bus.id_dst = 9; bus.id_reg_write = 1;
    step("fwd_mem");
    check("fwd_mem.const", bus.ex_op_a, 32'hAA);

    // No forwarding to r0.
    bus.id_rs = 0; bus.mem_dst = 0; bus.mem_data = 32'hFF; bus.rf_data1 = 32'h12;
    step("r0");
    check("r0.const", bus.ex_op_a, 32'h0);

    // Load-use: stall while the load is in ID/EX and in EX/MEM, accept at WB.
    issue_load_r4("lw");
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 4; bus.id_dst = 6; bus.id_reg_write = 1;
    bus.rf_data1 = 32'h33;
    step("lu_idex");
    bus.mem_reg_write = 1; bus.mem_is_load = 1; bus.mem_dst = 4; bus.mem_data = 32'hDEAD;
    step("lu_exmem");
    bus.mem_reg_write = 0; bus.mem_is_load = 0; bus.mem_dst = 0;
    bus.wb_reg_write = 1; bus.wb_dst = 4; bus.wb_data = 32'h77;
    step("lu_wb");
    check("lu_wb.const", bus.ex_op_a, BYPASS ? 32'h77 : 32'h33);

    // WB forwarding on rt.
    clear_inputs();
    bus.id_valid = 1; bus.id_rt = 7; bus.rf_data2 = 32'h11;
    bus.wb_reg_write = 1; bus.wb_dst = 7; bus.wb_data = 32'h55;
    step("fwd_wb");
    check("fwd_wb.const", bus.ex_op_b, BYPASS ? 32'h55 : 32'h11);

    // Back-pressure holds the entry, then flush drops it.
    bus.ex_ready = 0; bus.id_rt = 2; bus.rf_data2 = 32'h99; bus.wb_reg_write = 0;
    for (int i = 0; i < 3; i++) step("hold");
    check("hold.const", bus.ex_op_b, BYPASS ? 32'h55 : 32'h11);
    bus.flush = 1;
    step("flush");
    check("flush.const", {31'b0, bus.ex_valid}, 32'h0);

    // Flush together with ex_ready: flush still wins.
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 1; bus.rf_data1 = 32'h1234;
    step("pre_fr");
    bus.flush = 1; bus.ex_ready = 1;
    step("flush_ready");

    // Reset in the middle of a load-use stall.
    issue_load_r4("lw2");
    clear_inputs();
    bus.id_valid = 1; bus.id_rt = 4; bus.ex_ready = 0;
    step("stall2");
    reset = 1;
    step("rst_stall");
    reset = 0;
    step("after_rst");

    // Random traffic on a small register window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      bus.id_valid      = ($urandom_range(0, 3) != 0);
      bus.id_rs         = 5'($urandom_range(0, 3));
      bus.id_rt         = 5'($urandom_range(0, 3));
      bus.id_dst        = 5'($urandom_range(0, 3));
      bus.id_reg_write  = 1'($urandom_range(0, 1));
      bus.id_mem_read   = 1'($urandom_range(0, 1));
      bus.rf_data1      = $urandom;
      bus.rf_data2      = $urandom;
      bus.mem_reg_write = 1'($urandom_range(0, 1));
      bus.mem_is_load   = ($urandom_range(0, 3) == 0);
      bus.mem_dst       = 5'($urandom_range(0, 3));
      bus.mem_data      = $urandom;
      bus.wb_reg_write  = 1'($urandom_range(0, 1));
      bus.wb_dst        = 5'($urandom_range(0, 3));
      bus.wb_data       = $urandom;
      bus.flush         = ($urandom_range(0, 15) == 0);
      bus.ex_ready      = ($urandom_range(0, 3) != 0);
      reset             = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
